// File: rtl/pc_fetch_unit.sv
// Fetch-side program counter with branch-prediction tracking.
// Every accepted fetch pushes its predicted next word address into an
// in-order queue. Execute resolves the oldest entry. A mismatch flushes
// the pipeline, reloads cpc from the resolved address and inserts a
// one-cycle REDIRECT bubble.
module pc_fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int unsigned QDEPTH  = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        stall,
  input  logic        halt,
  input  logic        phit,
  input  logic [29:0] paddr,
  input  logic        res_valid,
  input  logic [29:0] res_next,
  output logic [29:0] cpc,
  output logic [31:0] imemaddr,
  output logic        iren,
  output logic        fetch_valid,
  output logic        flush,
  output logic [15:0] miss_cnt,
  output logic [15:0] res_cnt,
  output logic        q_err
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [29:0]   PC_RESET = PC_INIT[31:2];
  localparam logic [CW-1:0] Q_FULL   = CW'(QDEPTH);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_HALTED   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [29:0]   cpc_q, cpc_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   miss_cnt_q, miss_cnt_d;
  logic [15:0]   res_cnt_q, res_cnt_d;
  logic          q_err_q, q_err_d;

  logic [29:0]   q_mem [QDEPTH];

  logic          running;
  logic          res_active;
  logic          pop;
  logic          mismatch;
  logic          qfull;
  logic          push;
  logic [29:0]   pnext;

  // Handshake decode: the prediction, the pop and compare, and the fetch accept.
  // NOTE: combinational blocks use blocking '=' so that later statements see
  // the values computed by earlier statements. Sequential blocks use '<='.
  always_comb begin
    running    = (state_q == ST_RUN);
    res_active = res_valid && (state_q != ST_HALTED);
    pop        = res_active && (count_q != '0);
    mismatch   = pop && (q_mem[head_q] != res_next);
    // A pop in the same cycle frees a slot, so fullness is judged after it.
    qfull      = (count_q == Q_FULL) && !pop;
    pnext      = phit ? paddr : cpc_q + 30'd1;
    push       = nRST && running && ihit && !stall && !qfull && !mismatch;
  end

  // Next-state logic for the pc, the queue pointers, the counters and the FSM.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it
    // unassigned. A missing default would infer a latch.
    state_d    = state_q;
    cpc_d      = cpc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    miss_cnt_d = miss_cnt_q;
    res_cnt_d  = res_cnt_q;
    q_err_d    = q_err_q;

    if (mismatch) begin
      // Redirect wins over a concurrent fetch. Every younger prediction is stale.
      cpc_d   = res_next;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
    end else begin
      if (push) begin
        cpc_d  = pnext;
        tail_d = tail_q + AW'(1);
      end
      if (pop) head_d = head_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    if (pop && (res_cnt_q != 16'hFFFF)) res_cnt_d = res_cnt_q + 16'd1;
    if (res_active && (count_q == '0)) q_err_d = 1'b1;

    case (state_q)
      ST_RUN:      state_d = mismatch ? ST_REDIRECT : ST_RUN;
      ST_REDIRECT: state_d = mismatch ? ST_REDIRECT : ST_RUN;
      default:     state_d = ST_HALTED;
    endcase
    if (halt) state_d = ST_HALTED;
  end

  // Control and status registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ST_RUN;
      cpc_q      <= PC_RESET;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      miss_cnt_q <= '0;
      res_cnt_q  <= '0;
      q_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpc_q      <= cpc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      miss_cnt_q <= miss_cnt_d;
      res_cnt_q  <= res_cnt_d;
      q_err_q    <= q_err_d;
    end
  end

  // Prediction storage. A write at the tail stores the predicted next pc.
  // NOTE: the storage array has no reset. The occupancy count alone decides
  // which entries are valid, so a reset of the array would only add logic.
  always_ff @(posedge CLK) begin
    if (push) q_mem[tail_q] <= pnext;
  end

  assign cpc         = cpc_q;
  assign imemaddr    = {cpc_q, 2'b00};
  assign iren        = running;
  assign fetch_valid = push;
  assign flush       = mismatch && nRST;
  assign miss_cnt    = miss_cnt_q;
  assign res_cnt     = res_cnt_q;
  assign q_err       = q_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit. A cycle-level reference keeps a scoreboard queue
// of predicted addresses. An entry is pushed when a fetch is expected to be
// accepted, and popped when a resolution is driven. Each cycle the DUT outputs
// are compared with the reference, and directed checks cover fixed scenarios.
module tb_pc_fetch_unit;

  localparam int QD = 8;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit, stall, halt, phit, res_valid;
  logic [29:0] paddr, res_next;
  logic [29:0] cpc;
  logic [31:0] imemaddr;
  logic        iren, fetch_valid, flush, q_err;
  logic [15:0] miss_cnt, res_cnt;

  pc_fetch_unit #(.PC_INIT(32'h0000_0000), .QDEPTH(QD)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .stall(stall), .halt(halt),
    .phit(phit), .paddr(paddr), .res_valid(res_valid), .res_next(res_next),
    .cpc(cpc), .imemaddr(imemaddr), .iren(iren), .fetch_valid(fetch_valid),
    .flush(flush), .miss_cnt(miss_cnt), .res_cnt(res_cnt), .q_err(q_err)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference state: 0 = RUN, 1 = REDIRECT, 2 = HALTED.
  logic [29:0] m_cpc;
  int          m_state;
  logic [29:0] m_q[$];
  logic [15:0] m_miss, m_res;
  logic        m_qerr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_cpc   = 30'd0;
    m_state = 0;
    m_q.delete();
    m_miss  = 16'd0;
    m_res   = 16'd0;
    m_qerr  = 1'b0;
  endtask

  task automatic drive(input logic i, input logic s, input logic h, input logic p,
                       input logic [29:0] pa, input logic rv, input logic [29:0] rn);
    ihit = i; stall = s; halt = h; phit = p; paddr = pa; res_valid = rv; res_next = rn;
  endtask

  // One clock cycle: compare the outputs at the falling edge, advance the
  // reference, then return 1 time unit after the rising edge.
  task automatic step();
    logic        e_iren, popv, e_flush, e_full, e_fv;
    logic [29:0] pn;
    @(negedge CLK);
    e_iren  = (m_state == 0);
    popv    = res_valid && (m_state != 2) && (m_q.size() > 0);
    e_flush = popv && (m_q[0] != res_next);
    e_full  = (m_q.size() == QD) && !popv;
    e_fv    = e_iren && ihit && !stall && !e_full && !e_flush;
    pn      = phit ? paddr : m_cpc + 30'd1;

    check("cpc", 32'(cpc), 32'(m_cpc));
    check("imemaddr", imemaddr, {m_cpc, 2'b00});
    check("iren", 32'(iren), 32'(e_iren));
    check("fetch_valid", 32'(fetch_valid), 32'(e_fv));
    check("flush", 32'(flush), 32'(e_flush));
    check("miss_cnt", 32'(miss_cnt), 32'(m_miss));
    check("res_cnt", 32'(res_cnt), 32'(m_res));
    check("q_err", 32'(q_err), 32'(m_qerr));

    if (res_valid && (m_state != 2) && (m_q.size() == 0)) m_qerr = 1'b1;
    if (popv && (m_res != 16'hFFFF)) m_res++;
    if (e_flush) begin
      m_cpc = res_next;
      m_q.delete();
      if (m_miss != 16'hFFFF) m_miss++;
    end else begin
      if (popv) void'(m_q.pop_front());
      if (e_fv) begin
        m_q.push_back(pn);
        m_cpc = pn;
      end
    end
    if (halt)              m_state = 2;
    else if (m_state != 2) m_state = e_flush ? 1 : 0;

    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [29:0] rn;

    // Reset: drive busy inputs to show that reset still forces the outputs low.
    drive(1, 0, 0, 0, 30'd0, 1, 30'h5);
    m_reset();
    #12;
    check("rst_cpc", 32'(cpc), 32'd0);
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_q_err", 32'(q_err), 32'd0);
    check("rst_cnts", {miss_cnt, res_cnt}, 32'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    // A resolution while the queue is empty.
    drive(0, 0, 0, 0, 30'd0, 1, 30'h5);
    step();
    drive(0, 0, 0, 0, 30'd0, 0, 30'd0);
    step();
    check("empty_res_q_err_sticky", 32'(q_err), 32'd1);
    check("empty_res_cnts", {miss_cnt, res_cnt}, 32'd0);

    // Sequential fetches.
    drive(1, 0, 0, 0, 30'd0, 0, 30'd0);
    check("seq_cpc0", 32'(cpc), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("seq_cpc", 32'(cpc), 32'(i));
      check("seq_imemaddr", imemaddr, 32'(i * 4));
    end
    step();
    step();
    check("seq_cpc5", 32'(cpc), 32'd5);

    // Predicted-taken fetch, then in-order resolutions that all match.
    drive(1, 0, 0, 1, 30'h40, 0, 30'd0);
    step();
    check("taken_cpc", 32'(cpc), 32'h40);
    foreach (m_q[i]) begin
      drive(0, 0, 0, 0, 30'd0, 1, m_q[0]);
      #1;
      check("match_no_flush", 32'(flush), 32'd0);
      step();
    end
    check("match_res_cnt", 32'(res_cnt), 32'd6);
    check("match_miss_cnt", 32'(miss_cnt), 32'd0);

    // Mispredict with a concurrent fetch.
    drive(1, 0, 0, 1, 30'h6, 0, 30'd0);
    step();
    drive(1, 0, 0, 0, 30'd0, 1, 30'h80);
    #1;
    check("mp_flush", 32'(flush), 32'd1);
    check("mp_fetch_blocked", 32'(fetch_valid), 32'd0);
    step();
    check("mp_cpc", 32'(cpc), 32'h80);
    check("mp_miss_cnt", 32'(miss_cnt), 32'd1);
    check("mp_redirect_iren", 32'(iren), 32'd0);
    drive(1, 0, 0, 0, 30'd0, 0, 30'd0);
    step();
    check("mp_back_to_run", 32'(iren), 32'd1);
    check("mp_cpc_after_bubble", 32'(cpc), 32'h80);

    // Fill the queue.
    repeat (QD) step();
    check("full_cpc", 32'(cpc), 32'h88);
    #1;
    check("full_blocks_fetch", 32'(fetch_valid), 32'd0);
    step();
    check("full_cpc_hold", 32'(cpc), 32'h88);
    drive(1, 0, 0, 0, 30'd0, 1, 30'h81);
    #1;
    check("full_pop_allows_push", 32'(fetch_valid), 32'd1);
    step();
    drive(1, 0, 0, 0, 30'd0, 0, 30'd0);
    #1;
    check("full_occupancy_kept", 32'(fetch_valid), 32'd0);
    step();
    check("full_cpc_after", 32'(cpc), 32'h89);

    // Drain the queue, then stall.
    repeat (QD) begin
      drive(0, 0, 0, 0, 30'd0, 1, m_q[0]);
      step();
    end
    drive(1, 1, 0, 0, 30'd0, 0, 30'd0);
    step();
    step();
    check("stall_cpc_hold", 32'(cpc), 32'h89);

    // Random traffic: most resolutions match, a few mispredict.
    repeat (300) begin
      rn = ((m_q.size() > 0) && ($urandom_range(3) != 0)) ? m_q[0] : 30'($urandom);
      drive(logic'($urandom_range(3) != 0), logic'($urandom_range(3) == 0), 0,
            logic'($urandom_range(1)), 30'($urandom), logic'($urandom_range(1)), rn);
      step();
    end

    // Reset in the middle of operation discards the in-flight entries.
    drive(1, 0, 0, 0, 30'd0, 0, 30'd0);
    step();
    step();
    step();
    #2;
    nRST = 1'b0;
    m_reset();
    #1;
    check("midrst_cpc", 32'(cpc), 32'd0);
    check("midrst_fetch_valid", 32'(fetch_valid), 32'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    drive(0, 0, 0, 0, 30'd0, 1, 30'h5);
    step();
    check("midrst_queue_empty", 32'(q_err), 32'd1);
    drive(1, 0, 0, 0, 30'd0, 0, 30'd0);
    step();
    check("midrst_first_fetch", 32'(cpc), 32'd1);

    // Halt: HALTED ignores fetches and resolutions until reset.
    drive(1, 0, 1, 0, 30'd0, 0, 30'd0);
    step();
    check("halt_iren", 32'(iren), 32'd0);
    drive(1, 0, 0, 0, 30'd0, 1, 30'h3);
    repeat (3) step();
    check("halt_cpc_hold", 32'(cpc), 32'd2);
    check("halt_res_ignored", 32'(res_cnt), 32'd0);
    nRST = 1'b0;
    m_reset();
    #2;
    nRST = 1'b1;
    check("halt_rst_cpc", 32'(cpc), 32'd0);
    check("halt_rst_iren", 32'(iren), 32'd1);
    drive(1, 0, 0, 0, 30'd0, 0, 30'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter PC_INIT, default 32'h0000_0000, byte address of the first fetch; bits [1:0] are ignored.
REQ-002 Parameter QDEPTH, default 8, capacity of the in-flight prediction queue; a power of two, minimum 2.
REQ-003 CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 nRST  in  1  reset, asynchronous, active-low.
REQ-005 ihit  in  1  instruction memory returns the word at cpc this cycle.
REQ-006 stall  in  1  decode cannot accept an instruction this cycle.
REQ-007 halt  in  1  halt instruction seen at execute.
REQ-008 phit  in  1  predictor hit for cpc.
REQ-009 paddr  in  30  predictor target word address, valid when phit=1.
REQ-010 res_valid  in  1  execute resolves the oldest in-flight instruction this cycle.
REQ-011 res_next  in  30  actual next word address of that instruction.
REQ-012 cpc  out  30  current fetch word address, driven to the predictor and the instruction memory.
REQ-013 imemaddr  out  32  {cpc, 2'b00}.
REQ-014 iren  out  1  instruction read request.
REQ-015 fetch_valid  out  1  instruction accepted into decode this cycle.
REQ-016 flush  out  1  misprediction; downstream squashes all younger instructions.
REQ-017 miss_cnt  out  16  count of mispredictions, saturating.
REQ-018 res_cnt  out  16  count of resolutions, saturating.
REQ-019 q_err  out  1  sticky flag: resolution arrived while the queue was empty.

Function
REQ-020 The block shall implement the states RUN, REDIRECT and HALTED.
REQ-021 pnext shall be paddr when phit=1, else cpc+1, with modulo-2^30 wrap.
REQ-022 iren shall be 1 only in RUN.
REQ-023 fetch_valid shall equal RUN & ihit & !stall & !qfull & !flush.
REQ-024 On fetch_valid, cpc shall load pnext at the clock edge and pnext shall be pushed to the queue tail; the fetch latency to the next address is one cycle.
REQ-025 When fetch_valid=0 and there is no redirect, cpc shall hold.
REQ-026 On res_valid with a non-empty queue, the head entry shall be popped and compared against res_next.
REQ-027 A mismatch shall assert flush combinationally in the same cycle.
REQ-028 On the edge closing a flush cycle: cpc shall load res_next, the queue shall empty, miss_cnt shall increment, and the state shall go to REDIRECT.
REQ-029 A match shall pop the entry only; res_cnt shall increment on every valid pop, matched or not.
REQ-030 Push and pop in the same cycle without a mismatch shall leave the queue occupancy unchanged.
REQ-031 A push and a mismatch in the same cycle: the mismatch wins and the push is discarded.
REQ-032 A pop when the queue is full shall free space in the same cycle, so the push is allowed; qfull shall be evaluated after the pop.
REQ-033 res_valid with an empty queue shall set q_err, pop nothing, assert no flush and change no counter.
REQ-034 REDIRECT shall last exactly one cycle with iren=0, then return to RUN.
REQ-035 halt=1 in any state shall enter HALTED at the next edge; flush in the same cycle is still honoured for cpc and the counters.
REQ-036 HALTED shall be exited only by reset; in HALTED, iren=0 and res_valid is ignored.
REQ-037 Counters shall saturate at 16'hFFFF.
REQ-038 Queue pointers shall be log2(QDEPTH) bits wide with wrap, plus an occupancy count of log2(QDEPTH)+1 bits.

Reset
REQ-039 While nRST=0, the block shall hold cpc=PC_INIT[31:2], state RUN, queue empty, miss_cnt=0, res_cnt=0 and q_err=0.
REQ-040 While nRST=0, flush and fetch_valid shall be 0 because the queue is empty and reset forces them low.
REQ-041 Reset deassertion mid-operation shall discard all in-flight entries; the first fetch shall be from PC_INIT.

Verification
REQ-042 Sequential run: reset, PC_INIT=0, ihit=1, phit=0 for 3 cycles -> cpc 0,1,2,3; imemaddr 0,4,8,C.
REQ-043 Predicted taken: at cpc=5, phit=1, paddr=30'h40 -> cpc=30'h40 next cycle; queue holds 30'h40; later res_next=30'h40 -> no flush, res_cnt+1.
REQ-044 Mispredict: head entry=6, res_next=30'h80 with a concurrent fetch -> flush=1 that cycle; next cpc=30'h80, queue empty, miss_cnt=1, iren=0 one cycle, then RUN.
REQ-045 Full queue: QDEPTH=8, 8 fetches with no resolves -> fetch_valid=0 and cpc holds; a resolve with a concurrent fetch -> occupancy stays 8.
REQ-046 Empty resolve: res_valid=1 after reset -> q_err=1 sticky, flush=0, counters 0.
REQ-047 Halt and stall: stall=1 -> cpc holds; halt=1 -> HALTED, iren=0 stays 0 until nRST pulses low, then cpc=PC_INIT.
